// File: rtl/class_tree_pkg.sv
// Shared types and helpers for the run-time-loadable decision-tree engine.
package class_tree_pkg;

    localparam int unsigned FW_DEF = 6;
    localparam int unsigned AW_DEF = 7;
    localparam int unsigned CW_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Node word, MSB first: leaf, feature index, true child, false child (class in low bits).
    typedef struct packed {
        logic              leaf;
        logic [FW_DEF-1:0] feat;
        logic [AW_DEF-1:0] t_child;
        logic [AW_DEF-1:0] f_child;
    } node_t;

    function automatic int unsigned node_width(input int unsigned fw, input int unsigned aw);
        return 1 + fw + 2 * aw;
    endfunction

    localparam int unsigned NW_DEF = node_width(FW_DEF, AW_DEF);

    function automatic logic node_leaf(input node_t n);
        return n.leaf;
    endfunction

    function automatic logic [CW_DEF-1:0] node_class(input node_t n);
        return n.f_child[CW_DEF-1:0];
    endfunction

    function automatic node_t make_branch(input int unsigned feat, input int unsigned t_child,
                                          input int unsigned f_child);
        node_t n;
        n.leaf    = 1'b0;
        n.feat    = FW_DEF'(feat);
        n.t_child = AW_DEF'(t_child);
        n.f_child = AW_DEF'(f_child);
        return n;
    endfunction

    function automatic node_t make_leaf(input int unsigned cls);
        node_t n;
        n.leaf    = 1'b1;
        n.feat    = '0;
        n.t_child = '0;
        n.f_child = AW_DEF'(cls);
        return n;
    endfunction

endpackage

// File: rtl/class_tree_node_ram.sv
// Node table: register file with one synchronous write and one combinational read port.
module class_tree_node_ram #(
    parameter int unsigned AW = 7,
    parameter int unsigned NW = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [NW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [NW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [NW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/class_tree_engine.sv
// Sequential decision-tree classifier: one node per clock over a run-time loaded table.
module class_tree_engine
    import class_tree_pkg::*;
#(
    parameter int unsigned N_FEAT    = 51,
    parameter int unsigned FW        = 6,
    parameter int unsigned AW        = 7,
    parameter int unsigned CW        = 1,
    parameter int unsigned MAX_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_FEAT-1:0]            i,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CW-1:0]                o,
    output logic                         err,
    input  logic                         cfg_we,
    input  logic [AW-1:0]                cfg_addr,
    input  logic [node_width(FW, AW)-1:0] cfg_wdata,
    output logic                         cfg_busy
);

    localparam int unsigned NW = node_width(FW, AW);
    localparam int unsigned DW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    state_t              state_q, state_d;
    logic [N_FEAT-1:0]   i_lat_q, i_lat_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [DW-1:0]       depth_q, depth_d;
    logic [CW-1:0]       o_q, o_d;
    logic                err_q, err_d;

    logic [NW-1:0]       node_word;
    logic                n_leaf;
    logic [FW-1:0]       n_feat;
    logic [AW-1:0]       n_t_child;
    logic [AW-1:0]       n_f_child;
    logic                feat_oob;
    logic                depth_last;
    logic                cfg_wr_en;

    // Table writes land only while idle, so a sample accepted alongside sees the new word.
    assign cfg_wr_en = cfg_we && (state_q == ST_IDLE);

    class_tree_node_ram #(
        .AW (AW),
        .NW (NW)
    ) u_node_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (cfg_wr_en),
        .waddr_i (cfg_addr),
        .wdata_i (cfg_wdata),
        .raddr_i (ptr_q),
        .rdata_o (node_word)
    );

    assign n_leaf     = node_word[NW-1];
    assign n_feat     = node_word[NW-2 -: FW];
    assign n_t_child  = node_word[2*AW-1 -: AW];
    assign n_f_child  = node_word[AW-1:0];
    assign feat_oob   = 32'(n_feat) >= N_FEAT;
    assign depth_last = depth_q == DW'(MAX_DEPTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_lat_q <= '0;
            ptr_q   <= '0;
            depth_q <= '0;
            o_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_lat_q <= i_lat_d;
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            o_q     <= o_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_lat_d = i_lat_q;
        ptr_d   = ptr_q;
        depth_d = depth_q;
        o_d     = o_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    i_lat_d = i;
                    ptr_d   = '0;
                    depth_d = '0;
                    state_d = ST_WALK;
                end
            end
            ST_WALK: begin
                // Leaf wins over the error checks; depth limit also terminates table loops.
                if (n_leaf) begin
                    o_d     = n_f_child[CW-1:0];
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (feat_oob || depth_last) begin
                    o_d     = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    ptr_d   = i_lat_q[n_feat] ? n_t_child : n_f_child;
                    depth_d = depth_q + DW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = state_q == ST_IDLE;
    assign out_valid = state_q == ST_DONE;
    assign cfg_busy  = state_q != ST_IDLE;
    assign o         = o_q;
    assign err       = err_q;

endmodule
